// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register.
// Build option USR_ROTATE_EN (used by the top level) turns fill-shifts into rotates.
package usr_pkg;

    localparam int USR_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        USR_HOLD = 2'd0,
        USR_LOAD = 2'd1,
        USR_SHL  = 2'd2,
        USR_SHR  = 2'd3
    } usr_mode_t;

endpackage

// File: rtl/usr_mode_decode.sv
// Combinational priority encoder for the shift register controls:
// load beats shift-left, which beats shift-right; nothing asserted means hold.
module usr_mode_decode
    import usr_pkg::*;
(
    input  logic      load_i,
    input  logic      shl_i,
    input  logic      shr_i,
    output usr_mode_t mode_o
);

    always_comb begin
        mode_o = USR_HOLD;
        if (load_i) begin
            mode_o = USR_LOAD;
        end else if (shl_i) begin
            mode_o = USR_SHL;
        end else if (shr_i) begin
            mode_o = USR_SHR;
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// Parallel-load, bidirectional shift register with synchronous reset.
// Define USR_ROTATE_EN to make shifts rotate instead of filling from d.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             shiftLeft,
    input  logic             shiftRight,
    output logic [WIDTH-1:0] q
);

    usr_mode_t        mode;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    usr_mode_decode u_decode (
        .load_i (load),
        .shl_i  (shiftLeft),
        .shr_i  (shiftRight),
        .mode_o (mode)
    );

    always_comb begin
        q_d = q_q;
        case (mode)
            USR_LOAD: q_d = d;
`ifdef USR_ROTATE_EN
            USR_SHL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            USR_SHR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
`else
            // Shifts pull the vacated bit from the matching end of d.
            USR_SHL:  q_d = {q_q[WIDTH-2:0], d[0]};
            USR_SHR:  q_d = {d[WIDTH-1], q_q[WIDTH-1:1]};
`endif
            default:  q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised + directed bench for universal_shift_register: an arithmetic
// reference model queues the expected q for each edge, a monitor compares.
module tb_universal_shift_register;

    localparam int W = 4;
    localparam int FULL = 1 << W;

    typedef struct {
        logic [W-1:0] exp;
        string        tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] d = '0;
    logic         load = 1'b0;
    logic         shiftLeft = 1'b0;
    logic         shiftRight = 1'b0;
    logic [W-1:0] q;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   model = 0;

    always #5 clk = ~clk;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .d          (d),
        .load       (load),
        .shiftLeft  (shiftLeft),
        .shiftRight (shiftRight),
        .q          (q)
    );

    // Reference: the register seen as an unsigned integer 0..FULL-1.
    function automatic int next_value(int cur, bit r, bit l, bit sl, bit sr, int dv);
        int fill;
        if (r) return 0;
        if (l) return dv;
        if (sl) begin
`ifdef USR_ROTATE_EN
            fill = cur / (FULL / 2);
`else
            fill = dv % 2;
`endif
            return (cur * 2 + fill) % FULL;
        end
        if (sr) begin
`ifdef USR_ROTATE_EN
            fill = cur % 2;
`else
            fill = dv / (FULL / 2);
`endif
            return cur / 2 + fill * (FULL / 2);
        end
        return cur;
    endfunction

    // Drive one edge's controls on the falling edge and queue the expected q.
    task automatic step(input bit r, input bit l, input bit sl, input bit sr,
                        input int dv, input string tag);
        exp_t e;
        @(negedge clk);
        reset      = r;
        load       = l;
        shiftLeft  = sl;
        shiftRight = sr;
        d          = W'(dv);
        model      = next_value(model, r, l, sl, sr, dv);
        e.exp      = W'(model);
        e.tag      = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: q is registered, so every rising edge presents one response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (q !== e.exp) begin
                    failures++;
                    $display("FAIL %s: q=%b required=%b", e.tag, q, e.exp);
                end else begin
                    $display("ok   %s: q=%b", e.tag, q);
                end
            end
        end
    end

    initial begin
        int budget;
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 4'b1111, "reset_beats_load");
        step(0, 1, 0, 0, 4'b1010, "load_1010");
        step(0, 1, 0, 0, 4'b0011, "load_0011");
        step(0, 1, 0, 0, 4'b0011, "load_hold");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 4'b1011, "shl_fill");
        step(0, 1, 0, 0, 4'b1011, "load_1011");
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 4'b1010, "shr_fill");
        step(0, 0, 0, 1, 4'b1110, "shr_fill_dchg");
        step(0, 1, 1, 0, 4'b0101, "load_beats_shl");
        step(0, 1, 0, 0, 4'b1000, "load_1000");
        step(0, 0, 1, 1, 4'b0000, "shl_beats_shr");
        step(0, 1, 0, 0, 4'b1001, "load_1001");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 4'b0110, "hold");
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 4'b0110, "shl_from_1001");
        step(0, 1, 0, 0, 4'b1001, "load_1001b");
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 4'b0110, "shr_from_1001");
        step(0, 0, 1, 0, 4'b1111, "shl_pre_reset");
        step(1, 0, 1, 0, 4'b1111, "reset_mid_shift");
        step(0, 0, 1, 0, 4'b0001, "resume_after_reset");
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, FULL - 1)), "random");
        end
        step(0, 0, 0, 0, 0, "final_hold");

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parallel-load, bidirectional shift register: WIDTH bits wide, clocked, with a priority-encoded mode select.
- General-purpose datapath utility, used for serializer/deserializer front ends and bit-manipulation stages.
- Parallel input d serves as the load word and also supplies the serial fill bit during shifts.

Parameters:
- WIDTH, 4, register width in bits (legal: >= 2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- d  input  WIDTH  parallel load data; also the serial fill source during shifts
- load  input  1  parallel-load request
- shiftLeft  input  1  shift-left request (toward MSB)
- shiftRight  input  1  shift-right request (toward LSB)
- q  output  WIDTH  registered contents

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled only on rising clk.
- All state updates occur on the rising edge of clk. q is driven directly from the register, with no combinational path from inputs.
- Priority per edge, highest first: reset > load > shiftLeft > shiftRight > hold.
- reset=1: q <= 0 on that edge, regardless of other inputs. While reset is held, q stays 0. Deasserting reset mid-operation resumes normal modes on the next edge with q=0.
- load=1: q <= d.
- shiftLeft=1: q <= {q[WIDTH-2:0], d[0]}. The MSB is discarded and d[0] fills the LSB.
- shiftRight=1: q <= {d[WIDTH-1], q[WIDTH-1:1]}. The LSB is discarded and d[WIDTH-1] fills the MSB.
- Neither shift nor load asserted: q holds.
- Simultaneous events:
  - load with either shift: load wins.
  - shiftLeft with shiftRight: shiftLeft wins.
- Latency: exactly one clock from a sampled control to the updated q. No handshake.
- Power-up value before the first reset is undefined. The bench must apply reset first.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined: shifts rotate instead of filling from d.
  - Left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - Right: q <= {q[0], q[WIDTH-1:1]}.
  - Load, reset and priority are unchanged.
- Undefined (default): fill behaviour exactly as in Behaviour.

Decomposition:
- Package usr_pkg:
  - typedef enum usr_mode_t {USR_HOLD, USR_LOAD, USR_SHL, USR_SHR}.
  - localparam USR_DEFAULT_WIDTH = 4.
- One natural sub-module, usr_mode_decode: a combinational priority encoder mapping load/shiftLeft/shiftRight to usr_mode_t.
- Top level keeps only the register and next-state mux; reset is handled in the top-level always block.

Test Plan:
- Reset: reset=1 for 5 edges with load=1 and d=1111 -> q=0000 on every edge (reset beats load).
- Load: reset=0, load=1, d=1010 -> q=1010 after one edge. Then d=0011 -> q=0011 after one edge. Holds while load stays 1 with d unchanged.
- Shift left with fill, macro undefined: start q=0011, shiftLeft=1, d=1011 (d[0]=1) -> successive edges give q=0111, 1111, 1111.
- Shift right with fill: load 1011, then shiftRight=1, d=1010 (d[3]=1) -> q=1101, 1110, 1111. Changing d to 1110 mid-run keeps MSB fill at 1.
- Priority and hold:
  - load=1 with shiftLeft=1 and d=0101 -> q=0101.
  - shiftLeft=1 with shiftRight=1 from q=1000, d=0000 -> q=0000.
  - All controls 0 -> q unchanged for 5 edges.
  - reset=1 mid-shift -> q=0000 on the next edge.
- Rotate, USR_ROTATE_EN defined:
  - q=1001, shiftLeft=1 -> q=0011, 0110.
  - From 1001, shiftRight=1 -> q=1100, 0110.
  - d has no effect during shifts.
